mdu_divider: RTL and testbench

MDU_DIVIDER -- requirements
Module: mdu_divider

---
 rtl/mdu_divider.sv | 139 +++++++++++++
 tb/tb_mdu_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle restoring divider for signed/unsigned, full and word-width division and remainder
module mdu_divider #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [CONTROL_WIDTH-1:0] i_div_control,
  input  logic [DATA_WIDTH-1:0]    i_src_1,
  input  logic [DATA_WIDTH-1:0]    i_src_2,
  output logic                     o_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_result,
  output logic                     o_div_by_zero_flag,
  output logic                     o_overflow_flag
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int XW = DATA_WIDTH - WORD_WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, res_q, res_d;
  logic w_q, w_d, sel_q, sel_d, nq_q, nq_d, nr_q, nr_d, dz_q, dz_d, ov_q, ov_d;
  logic w_op, uns, a_neg, b_neg, div_zero, ovf, last;
  logic [DATA_WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_val, rem_nx, dvd_nx;
  logic [DATA_WIDTH:0] trial;

  // Signs are applied to the magnitudes, then W results are re-extended from bit WORD_WIDTH-1
  function automatic logic [DATA_WIDTH-1:0] fmt(input logic [DATA_WIDTH-1:0] q, r,
                                                input logic nq, nr, w, sel);
    logic [DATA_WIDTH-1:0] v;
    v = sel ? (nr ? -r : r) : (nq ? -q : q);
    return w ? {{XW{v[WORD_WIDTH-1]}}, v[WORD_WIDTH-1:0]} : v;
  endfunction

  // Operand extension, magnitudes and special-case detection on the incoming request
  always_comb begin
    w_op     = i_div_control[2];
    uns      = i_div_control[0];
    a_ext    = w_op ? {{XW{~uns & i_src_1[WORD_WIDTH-1]}}, i_src_1[WORD_WIDTH-1:0]} : i_src_1;
    b_ext    = w_op ? {{XW{~uns & i_src_2[WORD_WIDTH-1]}}, i_src_2[WORD_WIDTH-1:0]} : i_src_2;
    a_neg    = ~uns & a_ext[DATA_WIDTH-1];
    b_neg    = ~uns & b_ext[DATA_WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_val  = w_op ? {{(XW+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}} : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    div_zero = b_ext == '0;
    ovf      = ~uns & (a_ext == min_val) & (&b_ext);
  end

  // One restoring step: the quotient bit enters the dividend register from the bottom
  always_comb begin
    trial  = {rem_q, dvd_q[DATA_WIDTH-1]} - {1'b0, dvs_q};
    rem_nx = trial[DATA_WIDTH] ? {rem_q[DATA_WIDTH-2:0], dvd_q[DATA_WIDTH-1]} : trial[DATA_WIDTH-1:0];
    dvd_nx = {dvd_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    last   = cnt_q == (w_q ? CW'(WORD_WIDTH - 1) : CW'(DATA_WIDTH - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    w_d     = w_q;
    sel_d   = sel_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (i_start) begin
        w_d     = w_op;
        sel_d   = i_div_control[1];
        nq_d    = a_neg ^ b_neg;
        nr_d    = a_neg;
        dz_d    = div_zero;
        ov_d    = ovf;
        cnt_d   = '0;
        rem_d   = '0;
        dvs_d   = b_mag;
        dvd_d   = w_op ? a_mag << XW : a_mag;
        res_d   = fmt(div_zero ? '1 : a_ext, div_zero ? a_ext : '0, 1'b0, 1'b0, w_op, i_div_control[1]);
        state_d = (div_zero | ovf) ? DONE : CALC;
      end
      CALC: begin
        dvd_d   = dvd_nx;
        rem_d   = rem_nx;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        res_d   = last ? fmt(dvd_nx, rem_nx, nq_q, nr_q, w_q, sel_q) : res_q;
        state_d = last ? DONE : CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over any request
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      w_q     <= 1'b0;
      sel_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      w_q     <= w_d;
      sel_q   <= sel_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign o_ready            = state_q == IDLE;
  assign o_busy             = state_q == CALC;
  assign o_done             = state_q == DONE;
  assign o_result           = res_q;
  assign o_div_by_zero_flag = dz_q;
  assign o_overflow_flag    = ov_q;
endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: directed checks of the multi-cycle divider
module tb_mdu_divider;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_div_control = '0;
  logic [63:0] i_src_1 = '0;
  logic [63:0] i_src_2 = '0;
  logic        o_ready, o_busy, o_done, o_div_by_zero_flag, o_overflow_flag;
  logic [63:0] o_result;
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] DIV = 3'b000, DIVU = 3'b001, REM = 3'b010, REMU = 3'b011;
  localparam logic [2:0] DIVW = 3'b100, DIVUW = 3'b101, REMW = 3'b110;

  mdu_divider dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_div_control(i_div_control),
    .i_src_1(i_src_1), .i_src_2(i_src_2), .o_ready(o_ready), .o_busy(o_busy),
    .o_done(o_done), .o_result(o_result), .o_div_by_zero_flag(o_div_by_zero_flag),
    .o_overflow_flag(o_overflow_flag)
  );

  always #5 clk = ~clk;

  // Issues one request and returns at the negedge of the o_done cycle; cyc=0 means timeout
  task automatic do_op(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b, output int cyc);
    @(negedge clk);
    i_div_control = c;
    i_src_1 = a;
    i_src_2 = b;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      if (o_done) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ready, o_busy, o_done, o_div_by_zero_flag, o_overflow_flag} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 10000", {o_ready, o_busy, o_done, o_div_by_zero_flag, o_overflow_flag});
    end
    checks++;
    if (o_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", o_result);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_signed_div;
    int cyc;
    do_op(DIV, 64'd20, -64'sd3, cyc);
    checks++;
    if (cyc !== 65) begin errors++; $display("FAIL div_latency got %0d want 65", cyc); end
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL div_20_m3 got %h want fffffffffffffffa", o_result); end
    checks++;
    if ({o_div_by_zero_flag, o_overflow_flag} !== 2'b00) begin errors++; $display("FAIL div_flags got %b want 00", {o_div_by_zero_flag, o_overflow_flag}); end
    repeat (2) @(negedge clk);
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFA || o_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL result_hold got %h done %b ready %b want fffffffffffffffa 0 1", o_result, o_done, o_ready);
    end
    do_op(REM, 64'd20, -64'sd3, cyc);
    checks++;
    if (o_result !== 64'd2 || cyc !== 65) begin errors++; $display("FAIL rem_20_m3 got %h cyc %0d want 2 cyc 65", o_result, cyc); end
  endtask

  task automatic test_remainder;
    int cyc;
    do_op(REM, -64'sd7, 64'd2, cyc);
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffffffffffff", o_result); end
    do_op(REMU, 64'd100, 64'd7, cyc);
    checks++;
    if (o_result !== 64'd2) begin errors++; $display("FAIL remu_100_7 got %h want 2", o_result); end
    do_op(DIVU, 64'd100, 64'd7, cyc);
    checks++;
    if (o_result !== 64'd14) begin errors++; $display("FAIL divu_100_7 got %h want e", o_result); end
  endtask

  task automatic test_div_by_zero;
    int cyc;
    do_op(DIVU, 64'd5, 64'd0, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", cyc); end
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFF || o_div_by_zero_flag !== 1'b1 || o_overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL divu_dz got %h dz %b ov %b want ffffffffffffffff 1 0", o_result, o_div_by_zero_flag, o_overflow_flag);
    end
    do_op(REMU, 64'd5, 64'd0, cyc);
    checks++;
    if (o_result !== 64'd5 || o_div_by_zero_flag !== 1'b1) begin errors++; $display("FAIL remu_dz got %h dz %b want 5 1", o_result, o_div_by_zero_flag); end
    @(negedge clk);
    i_div_control = DIV;
    i_src_1 = 64'd20;
    i_src_2 = 64'd4;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_div_by_zero_flag !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL dz_clear got dz %b busy %b want 0 1", o_div_by_zero_flag, o_busy); end
    for (int k = 0; k < 100 && !o_done; k++) @(negedge clk);
    checks++;
    if (o_result !== 64'd5) begin errors++; $display("FAIL div_20_4 got %h want 5", o_result); end
  endtask

  task automatic test_overflow;
    int cyc;
    do_op(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
    checks++;
    if (o_result !== 64'h8000_0000_0000_0000 || o_overflow_flag !== 1'b1 || o_div_by_zero_flag !== 1'b0 || cyc !== 1) begin
      errors++;
      $display("FAIL div_ovf got %h ov %b dz %b cyc %0d want 8000000000000000 1 0 1", o_result, o_overflow_flag, o_div_by_zero_flag, cyc);
    end
    do_op(REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
    checks++;
    if (o_result !== 64'h0 || o_overflow_flag !== 1'b1 || cyc !== 1) begin
      errors++;
      $display("FAIL remw_ovf got %h ov %b cyc %0d want 0 1 1", o_result, o_overflow_flag, cyc);
    end
  endtask

  task automatic test_word;
    int cyc;
    do_op(DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, cyc);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL w_latency got %0d want 33", cyc); end
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL divuw got %h want fffffffffffffffe", o_result); end
    do_op(DIVW, 64'h1_0000_0010, 64'd2, cyc);
    checks++;
    if (o_result !== 64'd8 || cyc !== 33) begin errors++; $display("FAIL divw got %h cyc %0d want 8 33", o_result, cyc); end
    do_op(DIVW, 64'hFFFF_FFF8, 64'd2, cyc);
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL divw_neg got %h want fffffffffffffffc", o_result); end
  endtask

  task automatic test_reset_abort;
    bit seen;
    @(negedge clk);
    i_div_control = DIV;
    i_src_1 = 64'd1000;
    i_src_2 = 64'd3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", o_busy); end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_result !== 64'h0) begin
      errors++;
      $display("FAIL abort_ready got ready %b busy %b res %h want 1 0 0", o_ready, o_busy, o_result);
    end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen |= o_done;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    i_div_control = DIV;
    i_src_1 = 64'd20;
    i_src_2 = -64'sd3;
    i_start = 1'b1;
    @(negedge clk);
    i_div_control = DIVU;
    i_src_1 = 64'd100;
    i_src_2 = 64'd7;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      if (o_done) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFA || cyc !== 65) begin
      errors++;
      $display("FAIL start_held got %h cyc %0d want fffffffffffffffa 65", o_result, cyc);
    end
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_after_done got %b want 1", o_ready); end
    do_op(DIV, -64'sd100, -64'sd7, cyc);
    checks++;
    if (o_result !== 64'd14) begin errors++; $display("FAIL div_m100_m7 got %h want e", o_result); end
  endtask

  initial begin
    test_reset;
    test_signed_div;
    test_remainder;
    test_div_by_zero;
    test_overflow;
    test_word;
    test_reset_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
